// File: rtl/prefetch_rd_arbiter_pkg.sv
// Shared types for the prefetch read arbiter.
// FSM state encoding and a constant log2 helper.
package prefetch_rd_arbiter_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/prefetch_rr_pick.sv
// Round-robin request picker: first set req bit at or above ptr, wrapping.
// Purely combinational.
module prefetch_rr_pick
  import prefetch_rd_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);

  logic [W-1:0] k;

  // Scan farthest offset first so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    k       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt_idx = k;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prefetch_rd_arbiter.sv
// Bursting round-robin arbiter over N_CH show-ahead prefetch FIFOs.
// Define PREFETCH_ARB_CH0_PRIO_EN to give channel 0 strict priority.
module prefetch_rd_arbiter
  import prefetch_rd_arbiter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DW        = 64,
  parameter int BURST_LEN = 16
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [N_CH-1:0]          ch_vld,
  input  logic [N_CH*DW-1:0]       ch_data,
  output logic [N_CH-1:0]          ch_rd_en,
  output logic [DW-1:0]            out_data,
  output logic                     out_vld,
  input  logic                     out_ready,
  output logic [clog2(N_CH)-1:0]   out_ch,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     burst_abort
);

  localparam int CW = clog2(N_CH);
  localparam int BW = clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_CH   = CW'(N_CH - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  state_t        state, state_n;
  logic [CW-1:0] rr_ptr, rr_n, ch_n;
  logic [BW-1:0] beat_cnt, cnt_n;
  logic [DW-1:0] words [N_CH];

  logic [CW-1:0] rr_idx, gnt_idx;
  logic          rr_any, gnt_any, gnt_adv;
  logic          busy, cur_vld;

  for (genvar i = 0; i < N_CH; i++) begin : g_word
    assign words[i] = ch_data[i*DW +: DW];
  end

  prefetch_rr_pick #(
    .N (N_CH),
    .W (CW)
  ) u_pick (
    .req     (ch_vld),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

`ifdef PREFETCH_ARB_CH0_PRIO_EN
  assign gnt_any = ch_vld[0] | rr_any;
  assign gnt_idx = ch_vld[0] ? '0 : rr_idx;
  assign gnt_adv = ~ch_vld[0];
`else
  assign gnt_any = rr_any;
  assign gnt_idx = rr_idx;
  assign gnt_adv = 1'b1;
`endif

  assign busy    = (state == BURST);
  assign cur_vld = ch_vld[out_ch];

  always_comb begin
    out_vld  = busy & cur_vld;
    out_data = busy ? words[out_ch] : '0;
    ch_rd_en = '0;
    if (busy) ch_rd_en[out_ch] = out_ready;
    out_sop     = out_vld & (beat_cnt == '0);
    out_eop     = out_vld & (beat_cnt == LAST_BEAT);
    burst_abort = busy & ~cur_vld & (beat_cnt != '0);
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    ch_n    = out_ch;
    cnt_n   = beat_cnt;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_n = BURST;
          ch_n    = gnt_idx;
          cnt_n   = '0;
          if (gnt_adv)
            rr_n = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end
      end
      BURST: begin
        if (!cur_vld) begin
          state_n = IDLE;
        end else if (out_ready) begin
          cnt_n = beat_cnt + 1'b1;
          if (out_eop) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      out_ch   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      out_ch   <= ch_n;
      beat_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_prefetch_rd_arbiter.sv
// Self-checking bench: FIFO queues feed the arbiter, a transaction
// model predicts grants/beats, directed phases then random traffic.
module tb_prefetch_rd_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int BL = 16;

  logic            rd_clk = 1'b0;
  logic            rd_rst;
  logic [N-1:0]    ch_vld;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    ch_rd_en;
  logic [DW-1:0]   out_data;
  logic            out_vld;
  logic            out_ready;
  logic [1:0]      out_ch;
  logic            out_sop;
  logic            out_eop;
  logic            burst_abort;

  prefetch_rd_arbiter #(
    .N_CH      (N),
    .DW        (DW),
    .BURST_LEN (BL)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .ch_vld      (ch_vld),
    .ch_data     (ch_data),
    .ch_rd_en    (ch_rd_en),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .burst_abort (burst_abort)
  );

  always #5 rd_clk = ~rd_clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q [N][$];
  int            seqn [N];
  logic [N-1:0]  gate;

  bit m_busy;
  int m_ch, m_cnt, m_ptr;

  int pops, accepts, aborts, eops;
  int grants[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(int c, int n);
    repeat (n) begin
      q[c].push_back({32'(c), 32'(seqn[c])});
      seqn[c]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ch_vld[i] = (q[i].size() > 0) && gate[i];
      ch_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  // Next grant from the arbitration rules; -1 when nobody requests.
  function automatic int pick(logic [N-1:0] v, int p, output int np);
    np = p;
`ifdef PREFETCH_ARB_CH0_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) begin
        np = (c + 1) % N;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_ch   = 0;
    m_cnt  = 0;
    m_ptr  = 0;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model.
  task automatic cycle(bit rdy);
    bit ev, esop, eeop, eab;
    logic [N-1:0] erd;
    int c, np;
    out_ready = rdy;
    drive();
    #4;
    ev   = m_busy && ch_vld[m_ch];
    erd  = m_busy ? (N'(rdy) << m_ch) : '0;
    esop = ev && (m_cnt == 0);
    eeop = ev && (m_cnt == BL - 1);
    eab  = m_busy && !ch_vld[m_ch] && (m_cnt > 0);
    chk("out_vld", 64'(out_vld), 64'(ev));
    chk("ch_rd_en", 64'(ch_rd_en), 64'(erd));
    chk("out_sop", 64'(out_sop), 64'(esop));
    chk("out_eop", 64'(out_eop), 64'(eeop));
    chk("burst_abort", 64'(burst_abort), 64'(eab));
    if (ev) begin
      chk("out_ch", 64'(out_ch), 64'(m_ch));
      chk("out_data", out_data, q[m_ch][0]);
    end
    pops += $countones(ch_vld & ch_rd_en);
    if (eab) aborts++;
    if (ev && rdy) begin
      accepts++;
      if (eeop) eops++;
      if (esop) grants.push_back(m_ch);
      void'(q[m_ch].pop_front());
    end
    if (!m_busy) begin
      c = pick(ch_vld, m_ptr, np);
      if (c >= 0) begin
        m_busy = 1;
        m_ch   = c;
        m_cnt  = 0;
        m_ptr  = np;
      end
    end else if (!ch_vld[m_ch]) begin
      m_busy = 0;
    end else if (rdy) begin
      if (m_cnt == BL - 1) m_busy = 0;
      m_cnt++;
    end
    @(posedge rd_clk);
    #1;
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  initial begin
    int a0, e0, b0, g0;
    int exp_g [5];
    bit hit;
    pops = 0; accepts = 0; aborts = 0; eops = 0;
    for (int i = 0; i < N; i++) seqn[i] = 0;
    gate      = '1;
    out_ready = 1'b0;
    rd_rst    = 1'b1;
    model_reset();
    drive();
    @(posedge rd_clk);
    #1;
    push(0, 4);
    push(1, 4);
    out_ready = 1'b1;
    drive();
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'(0));
    chk("rst_rd_en", 64'(ch_rd_en), 64'(0));
    chk("rst_sop", 64'(out_sop), 64'(0));
    chk("rst_eop", 64'(out_eop), 64'(0));
    chk("rst_abort", 64'(burst_abort), 64'(0));
    chk("rst_out_ch", 64'(out_ch), 64'(0));
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    clear_q();

    // Back-to-back full bursts with every channel valid.
    push(0, 100);
    for (int i = 1; i < N; i++) push(i, 40);
    g0 = grants.size();
    e0 = eops;
    for (int i = 0; i < 5 * (BL + 1); i++) cycle(1'b1);
`ifdef PREFETCH_ARB_CH0_PRIO_EN
    exp_g = '{0, 0, 0, 0, 0};
`else
    exp_g = '{0, 1, 2, 3, 0};
`endif
    chk("rr_burst_count", 64'(grants.size() - g0), 64'(5));
    for (int i = 0; i < 5; i++)
      if (g0 + i < grants.size())
        chk("rr_order", 64'(grants[g0+i]), 64'(exp_g[i]));
    chk("full_eops", 64'(eops - e0), 64'(5));
    gate = '0;
    cycle(1'b1);
    clear_q();
    gate = '1;

    // Short channel-2 burst that runs dry mid-burst.
    a0 = accepts; b0 = aborts; e0 = eops;
    push(2, 5);
    for (int i = 0; i < 8; i++) cycle(1'b1);
    chk("short_beats", 64'(accepts - a0), 64'(5));
    chk("short_abort", 64'(aborts - b0), 64'(1));
    chk("short_eop", 64'(eops - e0), 64'(0));
    chk("short_idle", 64'(out_vld), 64'(0));

    // Ready toggling during a channel-3 burst.
    a0 = accepts;
    push(3, 10);
    for (int i = 0; i < 30; i++) cycle((i < 12) ? (i % 2 == 1) : 1'b1);
    chk("toggle_beats", 64'(accepts - a0), 64'(10));

    // Reset in the middle of a channel-1 burst.
    push(1, 20);
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (m_busy && m_ch == 1 && m_cnt == 7) hit = 1;
      else cycle(1'b1);
    end
    chk("reach_beat7", 64'(hit), 64'(1));
    drive();
    rd_rst = 1'b1;
    #1;
    chk("midrst_vld", 64'(out_vld), 64'(0));
    chk("midrst_rd_en", 64'(ch_rd_en), 64'(0));
    chk("midrst_sop", 64'(out_sop), 64'(0));
    chk("midrst_eop", 64'(out_eop), 64'(0));
    chk("midrst_abort", 64'(burst_abort), 64'(0));
    chk("midrst_ch", 64'(out_ch), 64'(0));
    model_reset();
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    push(0, 3);
    g0 = grants.size();
    for (int i = 0; i < 6; i++) cycle(1'b1);
    chk("post_rst_grants", 64'(grants.size() > g0), 64'(1));
    if (grants.size() > g0)
      chk("post_rst_ch0", 64'(grants[g0]), 64'(0));

    // Random valid gating, ready and refill.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) < 3) push(c, $urandom_range(1, 6));
        gate[c] = ($urandom_range(0, 99) < 90);
      end
      cycle($urandom_range(0, 99) < 70);
    end
    chk("pops_eq_accepts", 64'(pops), 64'(accepts));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prefetch_rd_arbiter.md
PREFETCH_RD_ARBITER -- requirements
Module: prefetch_rd_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4: number of prefetch-FIFO read ports shared, legal 2..8.
REQ-002 The block SHALL have parameter DW, default 64: read-data width per channel.
REQ-003 The block SHALL have parameter BURST_LEN, default 16: maximum beats per grant, legal 2..256.
REQ-004 The block SHALL have port rd_clk, input, 1: read-side clock, rising edge.
REQ-005 The block SHALL have port rd_rst, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port ch_vld, input, N_CH: per-channel show-ahead FIFO data valid.
REQ-007 The block SHALL have port ch_data, input, N_CH*DW: per-channel head word, channel i at bits [i*DW +: DW].
REQ-008 The block SHALL have port ch_rd_en, output, N_CH: per-channel pop; a pop occurs when ch_vld[i] and ch_rd_en[i] are both high.
REQ-009 The block SHALL have port out_data, output, DW: granted channel's head word.
REQ-010 The block SHALL have port out_vld, output, 1: out_data valid.
REQ-011 The block SHALL have port out_ready, input, 1: consumer accepts the beat when out_vld and out_ready are both high.
REQ-012 The block SHALL have port out_ch, output, clog2(N_CH): granted channel index.
REQ-013 The block SHALL have port out_sop, output, 1: first beat of a burst.
REQ-014 The block SHALL have port out_eop, output, 1: beat BURST_LEN-1 of a burst.
REQ-015 The block SHALL have port burst_abort, output, 1: one-cycle pulse when a burst ends early.

Function
- REQ-016 FSM states SHALL be IDLE and BURST.
- REQ-017 In IDLE, when any ch_vld is high, the block SHALL grant one channel, load out_ch and beat_cnt=0, and enter BURST on the next edge; arbitration costs one cycle per burst.
- REQ-018 Grant selection SHALL be round-robin: the first requesting channel starting at rr_ptr, searched upward with wrap N_CH-1 to 0.
- REQ-019 On grant of channel k, rr_ptr SHALL become (k+1) mod N_CH.
- REQ-020 In BURST, out_vld, out_data, ch_rd_en and the out_ready/pop path SHALL be combinational: out_vld = ch_vld[out_ch], out_data = ch_data[out_ch], ch_rd_en[out_ch] = out_ready; all other ch_rd_en SHALL be 0.
- REQ-021 In IDLE, out_vld and all ch_rd_en SHALL be 0.
- REQ-022 beat_cnt SHALL increment only on an accepted beat (out_vld & out_ready).
- REQ-023 out_sop SHALL be out_vld & (beat_cnt==0).
- REQ-024 out_eop SHALL be out_vld & (beat_cnt==BURST_LEN-1).
- REQ-025 An accepted beat with out_eop high SHALL return the FSM to IDLE.
- REQ-026 Early end: in BURST with beat_cnt>0 and ch_vld[out_ch] low, the block SHALL pulse burst_abort for one cycle and return to IDLE; no eop is issued for that burst.
- REQ-027 Early-end exception: in BURST with beat_cnt==0 and ch_vld[out_ch] low, the block SHALL return to IDLE with no abort pulse.
- REQ-028 out_ready low with out_vld high SHALL hold all state, with zero pops.
- REQ-029 A channel losing vld while stalled SHALL be handled per REQ-026 or REQ-027.
- REQ-030 No beat SHALL be duplicated or dropped: each pop corresponds to exactly one accepted beat.
- REQ-031 beat_cnt width SHALL be clog2(BURST_LEN); wrap never occurs because eop forces IDLE.

Reset
- REQ-032 While rd_rst is high: state=IDLE, rr_ptr=0, out_ch=0, beat_cnt=0; out_vld, out_sop, out_eop, burst_abort and ch_rd_en all 0.
- REQ-033 Reset mid-burst SHALL discard the burst with no pop in the reset cycle.
- REQ-034 Release SHALL be clean on the next rd_clk edge.

Configuration
- REQ-035 With macro PREFETCH_ARB_CH0_PRIO_EN defined, channel 0 SHALL win every IDLE arbitration when ch_vld[0] is high, and rr_ptr SHALL be unchanged by a channel-0 grant; the other channels remain round-robin.
- REQ-036 With PREFETCH_ARB_CH0_PRIO_EN undefined, arbitration SHALL be pure round-robin per REQ-018.

Structure
- REQ-037 The shared package SHALL hold the FSM state enum (IDLE, BURST) and a clog2 function.
- REQ-038 The round-robin search SHALL be one sub-module, prefetch_rr_pick: inputs req and ptr, outputs gnt_idx and gnt_any; purely combinational.

Verification
- REQ-039 All 4 channels always valid, out_ready=1 -> bursts of 16 beats each on out_ch 0,1,2,3,0; sop on beat 0, eop on beat 15; one idle cycle between bursts.
- REQ-040 Only ch2 valid, 5 words, then vld drops -> 5 beats on out_ch=2, burst_abort pulses once, no eop, FSM back to IDLE.
- REQ-041 out_ready toggles 1,0,1,0 during a burst -> ch_rd_en follows out_ready; beat_cnt advances only on 1; no pops while out_ready is 0.
- REQ-042 rd_rst asserted at beat 7 of a ch1 burst -> all outputs 0 within the same cycle; after release the first grant goes to ch0 if valid.
- REQ-043 PREFETCH_ARB_CH0_PRIO_EN defined, ch0 and ch3 continuously valid -> every grant goes to ch0; with ch0 idle, ch3 is granted.
- REQ-044 Scoreboard across random vld/ready -> per-channel output order equals input order; pop count equals accepted-beat count.
